pi_spi_slave: RTL and testbench
===============================

Name: pi_spi_slave

Overview:
Parametrised SPI slave for the Pi link, fully synchronous to the fabric clock sclk. It oversamples the Pi's SPI pins and supports any of the four SPI modes and any word width. Transfers run back-to-back while chip-select is low. A valid/ready handshake carries TX and RX words to the core logic, and sticky flags report overrun and underrun.

Parameters:
WIDTH, 8, bits per SPI word (2..32), MSB first
MODE, 0, SPI mode 0..3; CPOL = MODE[1], CPHA = MODE[0]
TX_IDLE, 0, word shifted out when no TX word is available (WIDTH bits)

Ports:
sclk  in  1  fabric clock; must be at least 8x the SPI clock frequency
reset  in  1  synchronous, active-high reset
spi_clk  in  1  SPI clock from Pi master (asynchronous)
spi_cs_n  in  1  SPI chip select from Pi, active low (asynchronous)
pi_MOSI  in  1  master-out data (asynchronous)
pi_MISO  out  1  slave-out data
pi_MISO_oe  out  1  MISO output enable; high while the slave is selected
tx_data  in  WIDTH  next word to send
tx_valid  in  1  tx_data is valid
tx_ready  out  1  one-cycle pulse: tx_data accepted this cycle
rx_data  out  WIDTH  last received word
rx_valid  out  1  rx_data holds an unread word
rx_ready  in  1  consumer takes rx_data
clr_status  in  1  clears both sticky flags
overrun  out  1  sticky flag: a received word was overwritten before it was read
underrun  out  1  sticky flag: TX_IDLE was sent because tx_valid was low

Behaviour:
- Reset (sclk edge with reset=1): state goes to IDLE. All outputs become 0, except pi_MISO, which takes TX_IDLE[WIDTH-1]. Synchronisers are cleared, with the spi_cs_n synchroniser preset to 1. Reset takes priority over every other event, including a transfer in progress.
- Synchronisation: each of spi_clk, spi_cs_n and pi_MOSI passes through 2 flops. A third flop on spi_clk and spi_cs_n provides edge detection. Pin-to-internal-event latency is 3 sclk cycles.
- Edge roles: the leading edge is rising when CPOL=0, falling when CPOL=1. With CPHA=0, sampling happens on the leading edge and shifting on the trailing edge. With CPHA=1, shifting happens on the leading edge and sampling on the trailing edge.
- FSM states are IDLE and SHIFT.
- IDLE -> SHIFT on a synced falling edge of spi_cs_n:
  - bit counter is cleared to 0;
  - the TX shift register is loaded from tx_data if tx_valid=1, with a tx_ready pulse;
  - otherwise it is loaded with TX_IDLE and underrun is set.
- pi_MISO always equals the TX shift register MSB.
- pi_MISO_oe equals the inverse of the synced spi_cs_n.
- In SHIFT:
  - On a sample edge, the RX shift register becomes {rx_shift[WIDTH-2:0], synced MOSI} and the bit counter increments.
  - On a shift edge, the TX shift register shifts left by one.
  - When CPHA=1, the first shift edge of each word does not shift, so the MSB is held for the first sample.
- Word completion is the WIDTH-th sample edge. In that same cycle:
  - rx_data is loaded with the full word and rx_valid is set;
  - the bit counter wraps to 0;
  - the next TX word is loaded with the same tx_valid/TX_IDLE rule as at CS fall;
  - for CPHA=0, the shift that would follow the loaded word's MSB is suppressed, so that bit is the one sampled next.
- RX handshake: rx_valid stays high until a cycle with rx_ready=1, then clears the next cycle. If a word completes while rx_valid=1 and rx_ready=0, rx_data is overwritten, rx_valid stays 1 and overrun is set. If completion and rx_ready=1 coincide, the new word is delivered and no overrun is flagged.
- CS rise (synced) in SHIFT returns the FSM to IDLE. A partial word is discarded without asserting rx_valid. A CS rise exactly at word completion delivers the word.
- Sticky flags: overrun and underrun stay set until clr_status=1. If clr_status coincides with a new set event, the flag ends up set.
- SPI edges while in IDLE are ignored.

Decomposition:
- Package pi_spi_pkg holds:
  - typedef spi_state_t {IDLE, SHIFT};
  - function deriving cpol/cpha from MODE;
  - constant SYNC_STAGES = 2.
- One sub-module, pi_spi_sync: a 2-flop synchroniser plus edge detector, instantiated for spi_clk and spi_cs_n.
- MOSI uses the same synchroniser without edge outputs.

Test Plan:
1. Mode 0, WIDTH=8, tx_data=0xA5 with tx_valid, Pi sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; one tx_ready pulse at CS fall; no flags.
2. Mode 0, two back-to-back words under one CS (TX 0x12 then 0x34, Pi sends 0xF0 then 0x0F) -> two rx_valid events 0xF0, 0x0F; second tx_ready at word-1 completion; MISO carries 0x12 then 0x34.
3. tx_valid=0 at CS fall, TX_IDLE=0 -> MISO all 0 for 8 bits; underrun=1; after clr_status, underrun=0.
4. rx_ready held 0 across two words 0x55, 0xAA -> rx_data=0xAA, overrun=1; one rx_ready cycle -> rx_valid=0.
5. CS raised after 5 sample edges, then a new transfer of 0x81 -> no rx_valid for the partial word; next rx_data=0x81.
6. Mode 3 (and separately mode 1), TX 0xC3, RX 0x5A -> rx_data=0x5A with MISO matching 0xC3. Also, reset asserted mid-word -> all outputs at reset values, and the next transfer is correct.

Source files
------------

// File: rtl/pi_spi_pkg.sv
// rtl/pi_spi_pkg.sv - shared types and helpers for the Pi SPI slave
package pi_spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int SYNC_STAGES = 2;

  // Returns {cpol, cpha} for an SPI mode number 0..3.
  function automatic logic [1:0] mode_cfg(input int mode);
    logic [1:0] cfg;
    cfg[1] = mode[1];
    cfg[0] = mode[0];
    return cfg;
  endfunction

endpackage

// File: rtl/pi_spi_sync.sv
// rtl/pi_spi_sync.sv - two-flop synchroniser with a third flop for edge detection
module pi_spi_sync
  import pi_spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   q_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
      q_d    <= RESET_VAL;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      q_d    <= stages[SYNC_STAGES-1];
    end
  end

  assign q    = stages[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/pi_spi_slave.sv
// rtl/pi_spi_slave.sv - oversampling SPI slave, any mode and word width, with TX/RX handshakes
module pi_spi_slave
  import pi_spi_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 0,
  parameter logic [WIDTH-1:0] TX_IDLE = '0
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             spi_clk,
  input  logic             spi_cs_n,
  input  logic             pi_MOSI,
  output logic             pi_MISO,
  output logic             pi_MISO_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             clr_status,
  output logic             overrun,
  output logic             underrun
);

  localparam logic [1:0]    CFG  = mode_cfg(MODE);
  localparam logic          CPOL = CFG[1];
  localparam logic          CPHA = CFG[0];
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic clk_q, clk_rise, clk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;

  pi_spi_sync #(.RESET_VAL(1'b0)) u_clk_sync (
    .clk  (sclk),
    .reset(reset),
    .din  (spi_clk),
    .q    (clk_q),
    .rise (clk_rise),
    .fall (clk_fall)
  );

  pi_spi_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk  (sclk),
    .reset(reset),
    .din  (spi_cs_n),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge sclk) begin
    if (reset) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], pi_MOSI};
  end

  // The new level of the synced clock tells a leading edge from a trailing one.
  logic clk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  assign clk_edge    = clk_rise | clk_fall;
  assign lead_edge   = clk_edge & (clk_q != CPOL);
  assign trail_edge  = clk_edge & (clk_q == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  spi_state_t      state, state_next;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_shift, rx_shift, rx_word;
  logic             skip_shift;
  logic             load_tx, word_done;

  assign rx_word = {rx_shift[WIDTH-2:0], mosi_sync[SYNC_STAGES-1]};

  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
        end
      end
      SHIFT: begin
        word_done = sample_edge && (bit_cnt == LAST);
        load_tx   = word_done;
        if (cs_rise) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      bit_cnt    <= '0;
      tx_shift   <= TX_IDLE;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      skip_shift <= 1'b0;
    end else begin
      if (state == SHIFT) begin
        if (sample_edge) begin
          rx_shift <= rx_word;
          bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
        end
        if (shift_edge) begin
          if (skip_shift) skip_shift <= 1'b0;
          else            tx_shift   <= {tx_shift[WIDTH-2:0], 1'b0};
        end
      end

      // A fresh word must not shift before its MSB has been sampled: CPHA=1
      // skips the first leading edge, CPHA=0 skips the trailing edge after reload.
      if (load_tx) begin
        tx_shift   <= tx_valid ? tx_data : TX_IDLE;
        skip_shift <= (state == IDLE) ? CPHA : 1'b1;
        if (state == IDLE) bit_cnt <= '0;
      end

      if (word_done) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      overrun  <= (overrun & ~clr_status) | (word_done & rx_valid & ~rx_ready);
      underrun <= (underrun & ~clr_status) | (load_tx & ~tx_valid);
    end
  end

  assign tx_ready   = load_tx & tx_valid & ~reset;
  assign pi_MISO    = tx_shift[WIDTH-1];
  assign pi_MISO_oe = ~cs_q;

endmodule

// File: tb/tb_pi_spi_slave.sv
// tb/tb_pi_spi_slave.sv - randomized bench for pi_spi_slave in modes 0, 1 and 3
module tb_pi_spi_slave;

  localparam int         W         = 8;
  localparam logic [7:0] IDLE_WORD = 8'h00;
  localparam int         H         = 8;

  logic       sclk = 1'b0;
  logic       reset;
  logic [2:0] spi_clk;
  logic [2:0] cs_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rx_ready;
  logic       clr_status;

  logic [2:0] miso, miso_oe, tx_ready_v, rx_valid_v, ovr_v, und_v;
  logic [7:0] rx_data_a [3];

  int n_checks = 0;
  int n_fail   = 0;
  int act      = 0;
  int n_txr    = 0;

  logic [7:0] txq[$];
  logic [7:0] tx_list[$];
  logic [7:0] mosi_q[$];
  logic [7:0] rxq[$];
  logic [7:0] misoq[$];

  initial forever #5 sclk = ~sclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pi_spi_slave #(
      .WIDTH  (W),
      .MODE   (g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .TX_IDLE(IDLE_WORD)
    ) u_dut (
      .sclk      (sclk),
      .reset     (reset),
      .spi_clk   (spi_clk[g]),
      .spi_cs_n  (cs_n[g]),
      .pi_MOSI   (mosi),
      .pi_MISO   (miso[g]),
      .pi_MISO_oe(miso_oe[g]),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready_v[g]),
      .rx_data   (rx_data_a[g]),
      .rx_valid  (rx_valid_v[g]),
      .rx_ready  (rx_ready),
      .clr_status(clr_status),
      .overrun   (ovr_v[g]),
      .underrun  (und_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mode_of(input int sel);
    return (sel == 0) ? 0 : ((sel == 1) ? 1 : 3);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  // TX producer: presents the head of txq, pops it after each accepted word.
  initial begin : feeder
    logic pop;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge sclk);
      pop = tx_ready_v[act];
      if (pop) n_txr++;
      @(posedge sclk);
      #1;
      if (pop && txq.size() > 0) void'(txq.pop_front());
      tx_valid = (txq.size() > 0);
      tx_data  = tx_valid ? txq[0] : 8'h00;
    end
  end

  // RX consumer: records every word handed over.
  initial forever begin
    @(negedge sclk);
    if (rx_valid_v[act] && rx_ready) rxq.push_back(rx_data_a[act]);
  end

  // Pi master: drives mosi_q MSB first, captures MISO into misoq.
  task automatic xfer(input int n, input int cut);
    logic       pol, pha;
    logic       bq[$];
    logic [7:0] got;
    int         total;
    pol = (mode_of(act) >= 2);
    pha = (mode_of(act) % 2 == 1);
    got = 8'h00;
    for (int k = 0; k < n; k++)
      for (int b = 7; b >= 0; b--) bq.push_back(mosi_q[k][b]);
    total = (cut >= 0) ? cut : n * 8;
    cs_n[act] = 1'b0;
    if (!pha) mosi = bq[0];
    tick(H);
    for (int i = 0; i < total; i++) begin
      spi_clk[act] = ~pol;
      if (pha) mosi = bq[i];
      else     got[7 - (i % 8)] = miso[act];
      tick(H);
      spi_clk[act] = pol;
      if (pha)                  got[7 - (i % 8)] = miso[act];
      else if (i + 1 < total)   mosi = bq[i + 1];
      tick(H);
      if (i % 8 == 7) misoq.push_back(got);
    end
    cs_n[act] = 1'b1;
    tick(H);
  endtask

  // One transfer under one CS; expectations come from the word-level rules:
  // n+1 loads for a complete transfer, one for a cut one, TX_IDLE when starved.
  task automatic run(input int sel, input int n, input int cut, input logic ready, input string tag);
    int         ntx, loads;
    logic [7:0] expw;
    act        = sel;
    rx_ready   = ready;
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    ntx = tx_list.size();
    foreach (tx_list[k]) txq.push_back(tx_list[k]);
    tick(3);
    n_txr = 0;
    rxq.delete();
    misoq.delete();
    xfer(n, cut);
    tick(2);
    loads = (cut >= 0) ? 1 : n + 1;
    check({tag, " tx_ready count"}, n_txr, (ntx < loads) ? ntx : loads);
    check({tag, " underrun"}, und_v[act], ntx < loads);
    if (cut < 0) begin
      for (int k = 0; k < n; k++) begin
        expw = (k < ntx) ? tx_list[k] : IDLE_WORD;
        check({tag, " miso word"}, misoq[k], expw);
      end
    end
    if (ready) begin
      check({tag, " rx count"}, rxq.size(), (cut >= 0) ? 0 : n);
      for (int k = 0; k < rxq.size() && k < n; k++) check({tag, " rx word"}, rxq[k], mosi_q[k]);
      check({tag, " overrun"}, ovr_v[act], 1'b0);
      check({tag, " rx_valid idle"}, rx_valid_v[act], 1'b0);
    end else begin
      check({tag, " rx_valid held"}, rx_valid_v[act], 1'b1);
      check({tag, " rx_data last"}, rx_data_a[act], mosi_q[n - 1]);
      check({tag, " overrun"}, ovr_v[act], n >= 2);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      check({tag, " rx_valid cleared"}, rx_valid_v[act], 1'b0);
    end
    txq.delete();
    tx_list.delete();
    mosi_q.delete();
    tick(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, cut;
    reset      = 1'b1;
    spi_clk    = 3'b100;
    cs_n       = 3'b111;
    mosi       = 1'b0;
    rx_ready   = 1'b0;
    clr_status = 1'b0;
    tick(3);
    for (int g = 0; g < 3; g++) begin
      check("reset miso", miso[g], IDLE_WORD[7]);
      check("reset oe", miso_oe[g], 1'b0);
      check("reset rx_valid", rx_valid_v[g], 1'b0);
      check("reset rx_data", rx_data_a[g], 8'h00);
      check("reset flags", {ovr_v[g], und_v[g]}, 2'b00);
    end
    reset = 1'b0;
    tick(4);

    tx_list = '{8'hA5, 8'h00};          mosi_q = '{8'h3C};
    run(0, 1, -1, 1'b1, "t1");
    tx_list = '{8'h12, 8'h34, 8'h56};   mosi_q = '{8'hF0, 8'h0F};
    run(0, 2, -1, 1'b1, "t2");
    mosi_q = '{8'h96};
    run(0, 1, -1, 1'b1, "t3");
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check("t3 underrun cleared", und_v[0], 1'b0);
    tx_list = '{8'h11, 8'h22, 8'h33};   mosi_q = '{8'h55, 8'hAA};
    run(0, 2, -1, 1'b0, "t4");
    tx_list = '{8'h77};                 mosi_q = '{8'hE7};
    run(0, 1, 5, 1'b1, "t5a");
    tx_list = '{8'h42, 8'h00};          mosi_q = '{8'h81};
    run(0, 1, -1, 1'b1, "t5b");
    tx_list = '{8'hC3, 8'h00};          mosi_q = '{8'h5A};
    run(2, 1, -1, 1'b1, "t6 mode3");
    tx_list = '{8'hC3, 8'h00};          mosi_q = '{8'h5A};
    run(1, 1, -1, 1'b1, "t6 mode1");

    // Abort a mode 1 word with reset while CS is still low.
    act = 1;
    cs_n[1] = 1'b0;
    tick(H);
    spi_clk[1] = 1'b1;
    tick(H);
    spi_clk[1] = 1'b0;
    tick(H);
    check("pre-reset underrun", und_v[1], 1'b1);
    check("pre-reset oe", miso_oe[1], 1'b1);
    reset = 1'b1;
    tick(2);
    check("mid reset miso", miso[1], IDLE_WORD[7]);
    check("mid reset oe", miso_oe[1], 1'b0);
    check("mid reset tx_ready", tx_ready_v[1], 1'b0);
    check("mid reset flags", {ovr_v[1], und_v[1], rx_valid_v[1]}, 3'b000);
    cs_n[1] = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    tx_list = '{8'h3E, 8'hD1};          mosi_q = '{8'h6B};
    run(1, 1, -1, 1'b1, "post reset");

    for (int it = 0; it < 18; it++) begin
      n   = $urandom_range(1, 3);
      cut = -1;
      if ($urandom_range(0, 4) == 0) begin
        n   = 1;
        cut = $urandom_range(1, 7);
      end
      r = $urandom_range(0, n + 1);
      for (int k = 0; k < r; k++) tx_list.push_back(8'($urandom));
      for (int k = 0; k < n; k++) mosi_q.push_back(8'($urandom));
      run($urandom_range(0, 2), n, cut, (cut >= 0) || ($urandom_range(0, 3) != 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
